// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared Feistel constants, state encoding and shift helper
package cipher_pkg;

    localparam int          DEF_DATAW = 10;
    localparam int unsigned SHIFT_A   = 5;
    localparam int unsigned SHIFT_B   = 1;
    localparam int          SHL_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Logical left shift, zero fill; callers truncate to their own word width.
    function automatic logic [SHL_W-1:0] shl(input logic [SHL_W-1:0] x, input int unsigned s);
        return x << s;
    endfunction

endpackage

// File: rtl/round_f.sv
// rtl/round_f.sv - Feistel round function f(x) = (x & (x<<A)) ^ (x<<B)
module round_f
    import cipher_pkg::*;
#(
    parameter int DATAW = DEF_DATAW
) (
    input  logic [DATAW-1:0] x,
    output logic [DATAW-1:0] y
);

    logic [SHL_W-1:0] xw;

    assign xw = SHL_W'(x);
    // Bitwise ops only, so truncating once at the end equals truncating each shift.
    assign y  = DATAW'((xw & shl(xw, SHIFT_A)) ^ shl(xw, SHIFT_B));

endmodule

// File: rtl/inv_round_iter.sv
// rtl/inv_round_iter.sv - iterative Feistel decrypt, one inverse round per clock
module inv_round_iter
    import cipher_pkg::*;
#(
    parameter  int DATAW  = DEF_DATAW,
    parameter  int ROUNDS = 32,
    localparam int CNTW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] ct_l,
    input  logic [DATAW-1:0] ct_r,
    output logic [CNTW-1:0]  key_addr,
    input  logic [DATAW-1:0] key_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] pt_l,
    output logic [DATAW-1:0] pt_r,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [CNTW-1:0]  cnt_q;
    logic [DATAW-1:0] l_q;
    logic [DATAW-1:0] r_q;
    logic [DATAW-1:0] f_r;

    round_f #(.DATAW(DATAW)) u_round_f (
        .x (r_q),
        .y (f_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        pt_l      = (state_q == DONE) ? l_q : '0;
        pt_r      = (state_q == DONE) ? r_q : '0;
    end

    // cnt_q only moves on accept and in RUN, so it doubles as the held key address.
    assign key_addr = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            l_q   <= '0;
            r_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_q   <= ct_l;
                        r_q   <= ct_r;
                        cnt_q <= CNTW'(ROUNDS - 1);
                    end
                end
                RUN: begin
                    l_q <= r_q;
                    r_q <= l_q ^ f_r ^ key_data;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inv_round_iter.md
Name: inv_round_iter

Overview:
- Iterative inverse of the Feistel round used on the encrypt side. Forward round: f(x) = (x & (x<<5)) ^ (x<<1), new_L = C ^ f(L) ^ R, new_R = L.
- Takes one ciphertext word pair, peels off ROUNDS rounds, one per clock, in reverse key order, and returns the plaintext pair.
- Sits behind the ciphertext input buffer. Reads round keys from an external combinational key store.
- Valid/ready handshake on both the input side and the output side.

Parameters:
- DATAW, 10, width of each half-word (L, R, round key).
- ROUNDS, 32, number of rounds to invert; must be ≥1.
- CNTW, $clog2(ROUNDS) (minimum 1), width of the round counter and key address; localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  ciphertext pair presented.
- in_ready  output  1  block can accept a pair.
- ct_l  input  DATAW  ciphertext left half.
- ct_r  input  DATAW  ciphertext right half.
- key_addr  output  CNTW  forward-round index of the key needed this cycle.
- key_data  input  DATAW  round key for key_addr, valid combinationally in the same cycle.
- out_valid  output  1  plaintext pair valid.
- out_ready  input  1  downstream accepts the plaintext pair.
- pt_l  output  DATAW  plaintext left half.
- pt_r  output  DATAW  plaintext right half.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, cnt=0, data regs l_q=r_q=0.
  - Outputs: in_ready=1 (combinational from IDLE), out_valid=0, busy=0, pt_l=pt_r=0, key_addr=0.
  - Reset mid-RUN or mid-DONE aborts immediately. The in-flight pair is discarded and never presented.
- Arithmetic:
  - Shifts are logical left shifts, zero fill, truncated to DATAW bits. No carries anywhere.
  - Inverse step on state (X, Y) with key K: next_l = Y; next_r = X ^ f(Y) ^ K.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: l_q<=ct_l, r_q<=ct_r, cnt<=ROUNDS-1, go to RUN.
  - RUN:
    - key_addr=cnt.
    - Each cycle apply the inverse step with K=key_data.
    - If cnt==0, go to DONE. Otherwise cnt<=cnt-1.
    - in_ready=0. in_valid is ignored.
  - DONE:
    - out_valid=1, pt_l=l_q, pt_r=r_q.
    - Data is held stable while out_ready=0.
    - On out_ready: go to IDLE. out_valid drops and in_ready rises on the next cycle. There is no same-cycle overlap of output handshake and input acceptance.
- Timing:
  - Latency: accept edge T, then out_valid first high in the cycle after edge T+ROUNDS.
  - Throughput: one pair per ROUNDS+2 cycles when out_ready is held high.
- Boundary cases:
  - ROUNDS=1: exactly one RUN cycle, with key_addr=0.
  - Keys are read in order ROUNDS-1 down to 0. The key store must not change during RUN; the block does not check this.
  - Outside RUN, key_addr holds its last value (0 after reset). key_data is ignored.
  - in_valid asserted during RUN or DONE is not back-pressured beyond in_ready=0. The source must hold data until in_ready.
  - out_ready asserted while not in DONE has no effect.

Decomposition:
- Shared package (cipher_pkg):
  - State encoding enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Shift constants SHIFT_A=5, SHIFT_B=1.
  - DATAW default.
- One sub-module, round_f: combinational, parameter DATAW, computes f(x) using the team's existing left-shift helper. Shared with the forward round so both directions use a single definition of f.
- The inverse-step XORs, FSM, counter and registers live in inv_round_iter.

Test Plan:
- ROUNDS=1, key[0]=0x155, ct=(0x000,0x001) → after 2 cycles pt=(0x001,0x157); key_addr=0 during RUN.
- ROUNDS=1, key[0]=0x000, ct=(0x000,0x3FF) → pt=(0x3FF,0x01E). Checks that the shift is truncated to 10 bits.
- ROUNDS=32, random keys, 1000 random plaintexts encrypted by the forward reference model then fed in → every pt matches the original. key_addr sequence is 31..0; out_valid rises exactly 33 cycles after accept.
- Output stall: hold out_ready=0 for 10 cycles in DONE → pt stable, out_valid=1, in_ready=0. Release → IDLE, and a new pair is accepted on the following cycle.
- Reset asserted mid-RUN (cnt=15) → next cycle state IDLE, out_valid=0, in_ready=1. A subsequent pair decrypts correctly.
- All-zero keys and ct=(0,0) with ROUNDS=32 → pt=(0,0). in_valid pulses during RUN are ignored, and exactly one output is produced.
